// File: rtl/alsu_pkg.sv
// Shared ALSU encodings: opcodes, flag bit positions, NOP pattern and issuer FSM states.
package alsu_pkg;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_XOR    = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_MULT   = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_ROTATE = 3'b101;

    localparam int unsigned FLAG_W = 7;

    // Flag vector order: {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
    localparam int unsigned FL_CIN       = 6;
    localparam int unsigned FL_SERIAL_IN = 5;
    localparam int unsigned FL_RED_A     = 4;
    localparam int unsigned FL_RED_B     = 3;
    localparam int unsigned FL_BYPASS_A  = 2;
    localparam int unsigned FL_BYPASS_B  = 1;
    localparam int unsigned FL_DIRECTION = 0;

    localparam logic [2:0]        NOP_OPCODE  = OP_AND;
    localparam logic [2:0]        NOP_OPERAND = 3'b000;
    localparam logic [FLAG_W-1:0] NOP_FLAGS   = 7'b0000100;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHold
    } issue_state_e;

    function automatic logic is_repeatable(input logic [2:0] opcode);
        return (opcode == OP_SHIFT) || (opcode == OP_ROTATE);
    endfunction

    // Mirrors the ALSU's own invalid-case detection so such commands never reach it.
    function automatic logic is_invalid_cmd(input logic [2:0] opcode,
                                            input logic [FLAG_W-1:0] flags);
        logic bypass;
        logic red;
        logic bad_op;
        logic red_op;
        bypass = flags[FL_BYPASS_A] | flags[FL_BYPASS_B];
        red    = flags[FL_RED_A] | flags[FL_RED_B];
        bad_op = (opcode == 3'b110) || (opcode == 3'b111);
        red_op = (opcode >= OP_ADD) && (opcode <= OP_ROTATE);
        return !bypass && (bad_op || (red_op && red));
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Synchronous FIFO holding packed ALSU commands; DEPTH must be a power of two.
module alsu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// Buffers ALSU commands and drives the ALSU's registered input pins, one command per cycle.
// Build option ALSU_CMD_FILTER_EN: discard commands the ALSU would flag invalid (pulses cmd_drop).
module alsu_cmd_issuer
    import alsu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned REP_W    = 3,
    parameter int unsigned ALSU_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_opcode,
    input  logic [2:0]             cmd_A,
    input  logic [2:0]             cmd_B,
    input  logic [FLAG_W-1:0]      cmd_flags,
    input  logic [REP_W-1:0]       cmd_rep,
    output logic [2:0]             alsu_opcode,
    output logic [2:0]             alsu_A,
    output logic [2:0]             alsu_B,
    output logic [FLAG_W-1:0]      alsu_flags,
    output logic                   issue_valid,
    output logic                   res_valid,
    output logic                   res_last,
    output logic                   cmd_drop,
    output logic [$clog2(DEPTH):0] fifo_count
);

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        a;
        logic [2:0]        b;
        logic [FLAG_W-1:0] flags;
        logic [REP_W-1:0]  rep;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    cmd_t              push_cmd;
    cmd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              head_drop;

    issue_state_e      state_q, state_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [2:0]        a_q, a_d;
    logic [2:0]        b_q, b_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              issue_valid_q, issue_valid_d;
    logic              tag_q, tag_d;
    logic              advance;

    logic [ALSU_LAT-1:0] res_valid_pipe_q;
    logic [ALSU_LAT-1:0] res_last_pipe_q;

    assign push_cmd = '{opcode: cmd_opcode, a: cmd_A, b: cmd_B, flags: cmd_flags, rep: cmd_rep};
    assign cmd_ready = !fifo_full;

    alsu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata (push_cmd),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef ALSU_CMD_FILTER_EN
    logic drop_q;

    assign head_drop = is_invalid_cmd(head.opcode, head.flags);
    assign cmd_drop  = drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= fifo_pop && head_drop;
        end
    end
`else
    assign head_drop = 1'b0;
    assign cmd_drop  = 1'b0;
`endif

    // State names what alsu_* currently carry: NOP, a fresh pop, or a repeat of the last pop.
    always_comb begin
        state_d       = state_q;
        rep_cnt_d     = rep_cnt_q;
        opcode_d      = opcode_q;
        a_d           = a_q;
        b_d           = b_q;
        flags_d       = flags_q;
        issue_valid_d = 1'b0;
        tag_d         = 1'b0;
        fifo_pop      = 1'b0;
        advance       = 1'b1;

        unique case (state_q)
            StIdle: begin
                advance = 1'b1;
            end
            StIssue, StHold: begin
                if (rep_cnt_q != '0) begin
                    advance       = 1'b0;
                    state_d       = StHold;
                    rep_cnt_d     = rep_cnt_q - 1'b1;
                    issue_valid_d = 1'b1;
                    tag_d         = (rep_cnt_q == REP_W'(1));
                end
            end
            default: begin
                advance = 1'b1;
            end
        endcase

        if (advance) begin
            if (!fifo_empty && !head_drop) begin
                fifo_pop      = 1'b1;
                state_d       = StIssue;
                opcode_d      = head.opcode;
                a_d           = head.a;
                b_d           = head.b;
                flags_d       = head.flags;
                issue_valid_d = 1'b1;
                if (is_repeatable(head.opcode) && (head.rep != '0)) begin
                    rep_cnt_d = head.rep;
                    tag_d     = 1'b0;
                end else begin
                    rep_cnt_d = '0;
                    tag_d     = 1'b1;
                end
            end else begin
                // Empty FIFO or a discarded head: park the ALSU on NOP.
                fifo_pop  = !fifo_empty;
                state_d   = StIdle;
                rep_cnt_d = '0;
                opcode_d  = NOP_OPCODE;
                a_d       = NOP_OPERAND;
                b_d       = NOP_OPERAND;
                flags_d   = NOP_FLAGS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            rep_cnt_q     <= '0;
            opcode_q      <= NOP_OPCODE;
            a_q           <= NOP_OPERAND;
            b_q           <= NOP_OPERAND;
            flags_q       <= NOP_FLAGS;
            issue_valid_q <= 1'b0;
            tag_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rep_cnt_q     <= rep_cnt_d;
            opcode_q      <= opcode_d;
            a_q           <= a_d;
            b_q           <= b_d;
            flags_q       <= flags_d;
            issue_valid_q <= issue_valid_d;
            tag_q         <= tag_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_pipe_q <= '0;
            res_last_pipe_q  <= '0;
        end else begin
            res_valid_pipe_q[0] <= issue_valid_q;
            res_last_pipe_q[0]  <= tag_q;
            for (int i = 1; i < int'(ALSU_LAT); i++) begin
                res_valid_pipe_q[i] <= res_valid_pipe_q[i-1];
                res_last_pipe_q[i]  <= res_last_pipe_q[i-1];
            end
        end
    end

    assign alsu_opcode = opcode_q;
    assign alsu_A      = a_q;
    assign alsu_B      = b_q;
    assign alsu_flags  = flags_q;
    assign issue_valid = issue_valid_q;
    assign res_valid   = res_valid_pipe_q[ALSU_LAT-1];
    assign res_last    = res_last_pipe_q[ALSU_LAT-1];

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: directed scenarios plus random traffic against a queue-based model.
module tb_alsu_cmd_issuer;

    localparam int DEPTH    = 4;
    localparam int REP_W    = 3;
    localparam int ALSU_LAT = 2;
`ifdef ALSU_CMD_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [2:0]       op;
        logic [2:0]       a;
        logic [2:0]       b;
        logic [6:0]       fl;
        logic [REP_W-1:0] rep;
    } cmd_s;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [2:0]       cmd_A;
    logic [2:0]       cmd_B;
    logic [6:0]       cmd_flags;
    logic [REP_W-1:0] cmd_rep;
    logic [2:0]       alsu_opcode;
    logic [2:0]       alsu_A;
    logic [2:0]       alsu_B;
    logic [6:0]       alsu_flags;
    logic             issue_valid;
    logic             res_valid;
    logic             res_last;
    logic             cmd_drop;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    alsu_cmd_issuer #(
        .DEPTH    (DEPTH),
        .REP_W    (REP_W),
        .ALSU_LAT (ALSU_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_A       (cmd_A),
        .cmd_B       (cmd_B),
        .cmd_flags   (cmd_flags),
        .cmd_rep     (cmd_rep),
        .alsu_opcode (alsu_opcode),
        .alsu_A      (alsu_A),
        .alsu_B      (alsu_B),
        .alsu_flags  (alsu_flags),
        .issue_valid (issue_valid),
        .res_valid   (res_valid),
        .res_last    (res_last),
        .cmd_drop    (cmd_drop),
        .fifo_count  (fifo_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of pending commands plus the command now on the ALSU pins.
    cmd_s       mq[$];
    bit         m_iv, m_tag, m_drop;
    logic [2:0] m_op, m_a, m_b;
    logic [6:0] m_fl;
    int         m_rem;
    bit         pv[ALSU_LAT];
    bit         pt[ALSU_LAT];
    bit         last_acc;

    int n_notready = 0, max_cnt = 0, n_iv = 0, n_sh = 0, n_rl = 0, n_rv = 0, n_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bad(input cmd_s c);
        int  o;
        bit  bypass, red;
        o      = int'(c.op);
        bypass = c.fl[2] | c.fl[1];
        red    = c.fl[4] | c.fl[3];
        return !bypass && ((o >= 6) || (o >= 2 && o <= 5 && red));
    endfunction

    function automatic cmd_s mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                input logic [6:0] fl, input logic [REP_W-1:0] rep);
        cmd_s c;
        c.op = op; c.a = a; c.b = b; c.fl = fl; c.rep = rep;
        return c;
    endfunction

    task automatic set_nop();
        m_iv = 0; m_tag = 0; m_rem = 0;
        m_op = 3'b000; m_a = 3'b000; m_b = 3'b000; m_fl = 7'b0000100;
    endtask

    task automatic model_reset();
        mq.delete();
        set_nop();
        m_drop = 0;
        for (int i = 0; i < ALSU_LAT; i++) begin
            pv[i] = 0;
            pt[i] = 0;
        end
    endtask

    task automatic model_step();
        cmd_s c;
        bit   acc;
        if (rst !== 1'b1) begin
            last_acc = 0;
            return;
        end
        for (int i = ALSU_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pt[i] = pt[i-1];
        end
        pv[0] = m_iv;
        pt[0] = m_tag;
        acc = cmd_valid && (mq.size() < DEPTH);
        m_drop = 0;
        if (m_iv && m_rem > 0) begin
            m_rem--;
            m_tag = (m_rem == 0);
        end else if (mq.size() > 0) begin
            c = mq.pop_front();
            if (FILT && bad(c)) begin
                set_nop();
                m_drop = 1;
            end else begin
                m_iv = 1;
                m_op = c.op; m_a = c.a; m_b = c.b; m_fl = c.fl;
                m_rem = (c.op == 3'b100 || c.op == 3'b101) ? int'(c.rep) : 0;
                m_tag = (m_rem == 0);
            end
        end else begin
            set_nop();
        end
        if (acc) mq.push_back(mk(cmd_opcode, cmd_A, cmd_B, cmd_flags, cmd_rep));
        last_acc = acc;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, release inputs just after.
    task automatic cyc(input bit v, input cmd_s c);
        cmd_valid  = v;
        cmd_opcode = c.op;
        cmd_A      = c.a;
        cmd_B      = c.b;
        cmd_flags  = c.fl;
        cmd_rep    = c.rep;
        @(posedge clk);
        model_step();
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, mk(3'b000, 3'b000, 3'b000, 7'b0, '0));
    endtask

    task automatic send(input cmd_s c);
        int tries = 0;
        do begin
            cyc(1'b1, c);
            tries++;
        end while (!last_acc && tries < 50);
        if (!last_acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        check("cmd_ready", cmd_ready, mq.size() < DEPTH);
        check("fifo_count", fifo_count, mq.size());
        check("issue_valid", issue_valid, m_iv);
        check("alsu_opcode", alsu_opcode, m_op);
        check("alsu_A", alsu_A, m_a);
        check("alsu_B", alsu_B, m_b);
        check("alsu_flags", alsu_flags, m_fl);
        check("res_valid", res_valid, pv[ALSU_LAT-1]);
        check("res_last", res_last, pv[ALSU_LAT-1] & pt[ALSU_LAT-1]);
        check("cmd_drop", cmd_drop, m_drop);
    end

    always @(negedge clk) begin
        if (cmd_ready !== 1'b1) n_notready++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (issue_valid === 1'b1) n_iv++;
        if (issue_valid === 1'b1 && alsu_opcode == 3'b100) n_sh++;
        if (res_last === 1'b1) n_rl++;
        if (res_valid === 1'b1) n_rv++;
        if (cmd_drop === 1'b1) n_drop++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_iv, b_sh, b_rl, b_rv, b_drop, b_nr;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_opcode = '0; cmd_A = '0; cmd_B = '0; cmd_flags = '0; cmd_rep = '0;
        model_reset();

        // Reset held three cycles, then released mid-cycle.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            @(negedge clk);
            check("t1_ready", cmd_ready, 1'b1);
            check("t1_iv", issue_valid, 1'b0);
            check("t1_flags", alsu_flags, 7'b0000100);
            check("t1_rv", res_valid, 1'b0);
        end

        // AND A=101 B=011: issue one cycle after accept, result two cycles later.
        send(mk(3'b000, 3'b101, 3'b011, 7'b0, '0));
        @(negedge clk);
        check("t2_count", fifo_count, 1);
        check("t2_iv0", issue_valid, 1'b0);
        idle(1);
        @(negedge clk);
        check("t2_iv", issue_valid, 1'b1);
        check("t2_A", alsu_A, 3'b101);
        check("t2_B", alsu_B, 3'b011);
        idle(1);
        @(negedge clk);
        check("t2_rv0", res_valid, 1'b0);
        idle(1);
        @(negedge clk);
        check("t2_rv", res_valid, 1'b1);
        check("t2_rl", res_last, 1'b1);
        idle(3);

        // Bypass then shift rep=2: three shift issue cycles, one res_last for the chain.
        send(mk(3'b000, 3'b000, 3'b000, 7'b0000100, '0));
        send(mk(3'b100, 3'b000, 3'b000, 7'b0100001, 3'd2));
        b_sh = n_sh; b_rl = n_rl; b_rv = n_rv;
        idle(10);
        check("t3_shift_issues", n_sh - b_sh, 3);
        check("t3_res_last", n_rl - b_rl, 2);
        check("t3_res_valid", n_rv - b_rv, 4);

        // Long shift holds the FIFO head while five more commands pile up behind it.
        b_nr = n_notready;
        send(mk(3'b100, 3'b001, 3'b010, 7'b0000001, 3'd7));
        for (int i = 0; i < 5; i++) send(mk(3'b001, 3'(i), 3'(i + 1), 7'b0, '0));
        idle(20);
        check("t4_notready_cycles", n_notready - b_nr, 5);
        check("t4_max_count", max_cnt, 4);

        // Opcode 110 with no bypass: dropped when filtering, issued otherwise.
        b_iv = n_iv; b_drop = n_drop; b_rv = n_rv;
        send(mk(3'b110, 3'b011, 3'b101, 7'b0, '0));
        idle(6);
        check("t5_drop", n_drop - b_drop, FILT ? 1 : 0);
        check("t5_issue", n_iv - b_iv, FILT ? 0 : 1);
        check("t5_res", n_rv - b_rv, FILT ? 0 : 1);
        idle(4);

        // Reset in the middle of a hold with two entries queued.
        send(mk(3'b101, 3'b110, 3'b000, 7'b0000000, 3'd7));
        send(mk(3'b000, 3'b111, 3'b111, 7'b0, '0));
        send(mk(3'b001, 3'b111, 3'b001, 7'b0, '0));
        check("t6_pre_count", fifo_count, 2);
        check("t6_pre_iv", issue_valid, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_count", fifo_count, 0);
        check("t6_iv", issue_valid, 1'b0);
        check("t6_op", alsu_opcode, 3'b000);
        check("t6_flags", alsu_flags, 7'b0000100);
        check("t6_rv", res_valid, 1'b0);
        idle(2);
        rst = 1'b1;
        b_iv = n_iv; b_rv = n_rv;
        idle(8);
        check("t6_no_issue", n_iv - b_iv, 0);
        check("t6_no_res", n_rv - b_rv, 0);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            cmd_s c;
            bit   v;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                model_reset();
                idle(2);
                rst = 1'b1;
            end
            v = ($urandom_range(0, 99) < 60);
            c.op  = 3'($urandom_range(0, 7));
            c.a   = 3'($urandom);
            c.b   = 3'($urandom);
            c.fl  = 7'($urandom);
            c.rep = ($urandom_range(0, 3) == 0) ? REP_W'($urandom) : '0;
            cyc(v, c);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
